uart_rx_mv: RTL and testbench

Parametrised second-generation UART receive path with 2-FF input synchroniser, 3-sample majority-vote bit recovery, 5–8 bit word length, optional parity, 1/2 stop-bit check, break detection, and a status-tagged receive FIFO of configurable depth. It sits between the `uart_rx` pin and the APB register block, driven by the baud generator's oversample tick `ctrl_shift_rx`. It supersedes the fixed 8-bit, 16-deep, single-sample receiver.

---
 rtl/uart_rx_mv.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_mv.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mv.sv
// uart_rx_mv: oversampled UART receiver with 3-sample majority vote, 5-8 bit words, optional parity,
//   1/2 stop bits, break detection and a status-tagged receive FIFO ({brk, fe, pe, data}).
// Ports: pclk/preset_n clock and async active-low reset; ctrl_* configuration, oversample tick
//   (ctrl_shift_rx) and FIFO pop (ctrl_data_rd); uart_rx serial pin; rx_* FIFO head, status,
//   occupancy, trigger, overrun and character timeout.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle character timeout counter.
module uart_rx_mv #(
  parameter int OVS = 16,
  parameter int FIFO_AW = 4,
  parameter int TMO_TICKS = 640
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               ctrl_en,
  input  logic [1:0]         ctrl_wlen,
  input  logic               ctrl_pen,
  input  logic               ctrl_ep,
  input  logic               ctrl_stb2,
  input  logic               ctrl_shift_rx,
  input  logic               ctrl_data_rd,
  input  logic [1:0]         ctrl_rxt,
  input  logic               uart_rx,
  output logic               rx_ne,
  output logic               rx_busy,
  output logic               rx_rxf,
  output logic               rx_ov,
  output logic               rx_pe,
  output logic               rx_fe,
  output logic               rx_brk,
  output logic [7:0]         rx_data,
  output logic [FIFO_AW:0]   rx_level,
  output logic               rx_tmo
);
  localparam int CW = $clog2(OVS);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] C_LO = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVS / 2);
  localparam logic [CW-1:0] C_HI = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] C_TOP = CW'(OVS - 1);
  localparam logic [FIFO_AW:0] L_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] L_HALF = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0] L_QTR = (FIFO_AW + 1)'(DEPTH / 4);
  localparam logic [FIFO_AW:0] L_TWO = (FIFO_AW + 1)'(2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;

  logic sync_q, uart_sync;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic s0, s1, bit_v, dec, wrap, fin, wr_req;
  logic [7:0] shreg;
  logic par, one_acc, fe_acc, brk_w, fe_w, pe_w;
  logic [FIFO_AW:0] wptr, rptr;
  logic [10:0] mem [DEPTH];
  logic [10:0] head;
  logic empty, full, rd, wr;

  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) {sync_q, uart_sync} <= 2'b11;
    else {sync_q, uart_sync} <= {uart_rx, sync_q};

  // third sample is the live synchroniser output on the decision tick
  assign bit_v = (s0 & s1) | (s0 & uart_sync) | (s1 & uart_sync);
  assign dec = ctrl_shift_rx && cnt == C_HI && state != IDLE;
  assign wrap = ctrl_shift_rx && cnt == C_TOP;
  assign fin = dec && idx == {2'b00, ctrl_stb2};

  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    wr_req = 1'b0;
    case (state)
      IDLE:   state_nx = uart_sync ? IDLE : START;
      START:  state_nx = (dec && bit_v) ? IDLE : wrap ? DATA : START;
      DATA:   state_nx = (wrap && idx == {1'b1, ctrl_wlen}) ? (ctrl_pen ? PARITY : STOP) : DATA;
      PARITY: state_nx = wrap ? STOP : PARITY;
      STOP: begin
        wr_req = fin;
        state_nx = fin ? IDLE : STOP;
      end
      default: state_nx = IDLE;
    endcase
    if (!ctrl_en) begin
      state_nx = IDLE;
      wr_req = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      cnt <= '0;
      idx <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      shreg <= '0;
      par <= 1'b0;
      one_acc <= 1'b0;
      fe_acc <= 1'b0;
    end else begin
      cnt <= (!ctrl_en || state == IDLE) ? '0 : !ctrl_shift_rx ? cnt : (cnt == C_TOP) ? '0 : cnt + CW'(1);
      idx <= (!ctrl_en || state == IDLE || state_nx != state) ? '0 : wrap ? idx + 3'd1 : idx;
      if (ctrl_shift_rx && cnt == C_LO) s0 <= uart_sync;
      if (ctrl_shift_rx && cnt == C_MID) s1 <= uart_sync;
      if (state == IDLE) begin
        shreg <= '0;
        par <= 1'b0;
        one_acc <= 1'b0;
        fe_acc <= 1'b0;
      end else if (dec) begin
        if (state == DATA) shreg[idx] <= bit_v;
        if (state == DATA || state == PARITY) par <= par ^ bit_v;
        if (state != START) one_acc <= one_acc | bit_v;
        if (state == STOP) fe_acc <= fe_acc | !bit_v;
      end
    end

  // par is the XOR of data and parity bits: even parity expects 0, odd expects 1
  assign brk_w = !(one_acc | bit_v);
  assign fe_w = brk_w | fe_acc | !bit_v;
  assign pe_w = ctrl_pen & (par ^ !ctrl_ep);

  assign empty = wptr == rptr;
  assign full = (wptr[FIFO_AW] != rptr[FIFO_AW]) && (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign rd = ctrl_en && ctrl_data_rd && !empty;
  assign wr = wr_req && (!full || rd);

  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      wptr <= '0;
      rptr <= '0;
      rx_ov <= 1'b0;
    end else begin
      wptr <= ctrl_en ? wptr + (FIFO_AW + 1)'(wr) : rptr;
      rptr <= rptr + (FIFO_AW + 1)'(rd);
      rx_ov <= !ctrl_en ? 1'b0 : (wr_req && !wr) ? 1'b1 : ctrl_data_rd ? 1'b0 : rx_ov;
    end

  always_ff @(posedge pclk)
    if (wr) mem[wptr[FIFO_AW-1:0]] <= {brk_w, fe_w, pe_w, shreg};

  assign head = mem[rptr[FIFO_AW-1:0]];
  assign {rx_brk, rx_fe, rx_pe, rx_data} = empty ? 11'd0 : head;
  assign rx_level = wptr - rptr;
  assign rx_ne = !empty;
  assign rx_busy = state != IDLE;
  assign rx_rxf = ctrl_rxt == 2'b00 ? rx_level == L_FULL :
                  ctrl_rxt == 2'b01 ? rx_level >= L_HALF :
                  ctrl_rxt == 2'b10 ? rx_level >= L_QTR : rx_level >= L_TWO;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TMO_TICKS + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) tcnt <= '0;
    else tcnt <= (!ctrl_en || wr || ctrl_data_rd) ? '0 :
                 (state == IDLE && !empty && ctrl_shift_rx && !rx_tmo) ? tcnt + TW'(1) : tcnt;
  assign rx_tmo = tcnt == TW'(TMO_TICKS);
`else
  // constant 0; the comparison keeps TMO_TICKS referenced in this build
  assign rx_tmo = TMO_TICKS < 0;
`endif
endmodule

// File: tb/tb_uart_rx_mv.sv
// tb_uart_rx_mv: randomized self-checking bench for uart_rx_mv against a frame-level FIFO model
module tb_uart_rx_mv;
  localparam int DEPTH = 16;
  logic pclk = 1'b0, preset_n = 1'b0, ctrl_en = 1'b0, ctrl_pen = 1'b0, ctrl_ep = 1'b0, ctrl_stb2 = 1'b0;
  logic ctrl_shift_rx = 1'b0, ctrl_data_rd = 1'b0, uart_rx = 1'b1;
  logic [1:0] ctrl_wlen = 2'b11, ctrl_rxt = 2'b00;
  logic rx_ne, rx_busy, rx_rxf, rx_ov, rx_pe, rx_fe, rx_brk, rx_tmo;
  logic [7:0] rx_data;
  logic [4:0] rx_level;
  int total = 0, bad = 0;
  logic [10:0] q[$];
  logic m_ov = 1'b0;

  uart_rx_mv #(.OVS(16), .FIFO_AW(4), .TMO_TICKS(640)) dut (
    .pclk(pclk), .preset_n(preset_n), .ctrl_en(ctrl_en), .ctrl_wlen(ctrl_wlen), .ctrl_pen(ctrl_pen),
    .ctrl_ep(ctrl_ep), .ctrl_stb2(ctrl_stb2), .ctrl_shift_rx(ctrl_shift_rx), .ctrl_data_rd(ctrl_data_rd),
    .ctrl_rxt(ctrl_rxt), .uart_rx(uart_rx), .rx_ne(rx_ne), .rx_busy(rx_busy), .rx_rxf(rx_rxf),
    .rx_ov(rx_ov), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_brk(rx_brk), .rx_data(rx_data),
    .rx_level(rx_level), .rx_tmo(rx_tmo)
  );

  always #5 pclk = ~pclk;

  initial forever begin
    repeat (3) @(negedge pclk);
    ctrl_shift_rx = 1'b1;
    @(negedge pclk);
    ctrl_shift_rx = 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] obs();
    return {rx_ne, rx_ov, rx_level, rx_brk, rx_fe, rx_pe, rx_data};
  endfunction

  function automatic logic [17:0] exp_st();
    logic [10:0] h;
    h = q.size() != 0 ? q[0] : 11'd0;
    return {q.size() != 0, m_ov, 5'(q.size()), h};
  endfunction

  function automatic void m_push(input logic [10:0] e);
    if (q.size() == DEPTH) m_ov = 1'b1;
    else q.push_back(e);
  endfunction

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge pclk); while (!ctrl_shift_rx);
    end
    #1;
  endtask

  task automatic rd();
    @(negedge pclk) ctrl_data_rd = 1'b1;
    @(negedge pclk) ctrl_data_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    m_ov = 1'b0;
  endtask

  task automatic flush();
    @(negedge pclk) ctrl_en = 1'b0;
    @(negedge pclk) ctrl_en = 1'b1;
    q.delete();
    m_ov = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit ep, input bit stb2,
                      input bit bad_par, input bit bad_s1, input bit bad_s2, input int gbit);
    logic bits[$];
    logic [7:0] dm;
    logic p;
    bit brk, fe, pe;
    dm = d & 8'((1 << nb) - 1);
    p = (ep ? ^dm : ~^dm) ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    if (pen) bits.push_back(p);
    bits.push_back(!bad_s1);
    if (stb2) bits.push_back(!bad_s2);
    ctrl_wlen = 2'(nb - 5);
    ctrl_pen = pen;
    ctrl_ep = ep;
    ctrl_stb2 = stb2;
    ticks(1);
    foreach (bits[i]) begin
      uart_rx = bits[i];
      if (i == gbit) begin
        ticks(8);
        uart_rx = ~bits[i];
        ticks(1);
        uart_rx = bits[i];
        ticks(7);
      end else ticks(16);
    end
    uart_rx = 1'b1;
    ticks(20);
    pe = pen && ((($countones(dm) + int'(p)) & 1) == int'(ep));
    brk = dm == 8'h00 && !(pen && p) && bad_s1 && (!stb2 || bad_s2);
    fe = brk || bad_s1 || (stb2 && bad_s2);
    m_push({brk, fe, pe, brk ? 8'h00 : dm});
  endtask

  task automatic test_reset();
    total++;
    if ({rx_busy, rx_rxf, rx_tmo, obs()} !== {3'b000, exp_st()}) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", {rx_busy, rx_rxf, rx_tmo, obs()}, {3'b000, exp_st()});
    end
    @(negedge pclk) preset_n = 1'b1;
    ctrl_en = 1'b1;
    repeat (4) @(negedge pclk);
    total++;
    if ({rx_busy, rx_rxf, rx_tmo, obs()} !== {3'b000, exp_st()}) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", {rx_busy, rx_rxf, rx_tmo, obs()}, {3'b000, exp_st()});
    end
  endtask

  task automatic test_8n1();
    send(8'hA5, 8, 0, 0, 0, 0, 0, 0, -1);
    total++;
    if (obs() !== exp_st()) begin
      bad++;
      $display("FAIL 8n1_rx: got %h want %h", obs(), exp_st());
    end
    rd();
    total++;
    if (obs() !== exp_st()) begin
      bad++;
      $display("FAIL 8n1_read: got %h want %h", obs(), exp_st());
    end
  endtask

  task automatic test_7e2_err();
    send(8'h35, 7, 1, 1, 1, 1, 0, 1, -1);
    total++;
    if (obs() !== exp_st()) begin
      bad++;
      $display("FAIL 7e2_err: got %h want %h", obs(), exp_st());
    end
    rd();
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    ticks(1);
    uart_rx = 1'b1;
    ticks(30);
    total++;
    if ({rx_busy, obs()} !== {1'b0, exp_st()}) begin
      bad++;
      $display("FAIL glitch_start: got %h want %h", {rx_busy, obs()}, {1'b0, exp_st()});
    end
    send(8'h5A, 8, 0, 0, 0, 0, 0, 0, 3);
    send(8'hC3, 8, 1, 0, 0, 0, 0, 0, 0);
    send(8'h0F, 8, 0, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs() !== exp_st()) begin
        bad++;
        $display("FAIL glitch_data%0d: got %h want %h", i, obs(), exp_st());
      end
      rd();
    end
  endtask

  task automatic test_random();
    int nb, len, g;
    bit pen, stb2;
    for (int i = 0; i < 6; i++) begin
      nb = $urandom_range(5, 8);
      pen = 1'($urandom);
      stb2 = 1'($urandom);
      len = 2 + nb + int'(pen) + int'(stb2);
      g = $urandom_range(0, len);
      send(8'($urandom), nb, pen, 1'($urandom), stb2, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, g);
      total++;
      if (obs() !== exp_st()) begin
        bad++;
        $display("FAIL random_rx%0d: got %h want %h", i, obs(), exp_st());
      end
    end
    for (int i = 0; i < 6; i++) begin
      rd();
      total++;
      if (obs() !== exp_st()) begin
        bad++;
        $display("FAIL random_rd%0d: got %h want %h", i, obs(), exp_st());
      end
    end
  endtask

  task automatic test_break();
    ctrl_wlen = 2'b11;
    ctrl_pen = 1'b0;
    ctrl_stb2 = 1'b0;
    ticks(1);
    uart_rx = 1'b0;
    ticks(176);
    m_push({1'b1, 1'b1, 1'b0, 8'h00});
    total++;
    if ({rx_busy, obs()} !== {1'b1, exp_st()}) begin
      bad++;
      $display("FAIL break: got %h want %h", {rx_busy, obs()}, {1'b1, exp_st()});
    end
    uart_rx = 1'b1;
    ticks(4);
    flush();
    total++;
    if ({rx_busy, obs()} !== {1'b0, exp_st()}) begin
      bad++;
      $display("FAIL break_flush: got %h want %h", {rx_busy, obs()}, {1'b0, exp_st()});
    end
  endtask

  task automatic test_overrun();
    ctrl_rxt = 2'b01;
    for (int i = 0; i < 17; i++) begin
      send(8'($urandom), 8, 0, 0, 0, 0, 0, 0, -1);
      total++;
      if ({rx_rxf, obs()} !== {q.size() >= DEPTH / 2, exp_st()}) begin
        bad++;
        $display("FAIL overrun_fill%0d: got %h want %h", i, {rx_rxf, obs()}, {q.size() >= DEPTH / 2, exp_st()});
      end
    end
    ctrl_rxt = 2'b00;
    #1;
    total++;
    if (rx_rxf !== (q.size() == DEPTH)) begin
      bad++;
      $display("FAIL rxf_full: got %b want %b", rx_rxf, q.size() == DEPTH);
    end
    rd();
    total++;
    if ({rx_rxf, obs()} !== {q.size() == DEPTH, exp_st()}) begin
      bad++;
      $display("FAIL overrun_read: got %h want %h", {rx_rxf, obs()}, {q.size() == DEPTH, exp_st()});
    end
  endtask

  task automatic test_flush();
    flush();
    for (int i = 0; i < 3; i++) send(8'($urandom), 8, 0, 0, 0, 0, 0, 0, -1);
    total++;
    if (obs() !== exp_st()) begin
      bad++;
      $display("FAIL flush_fill: got %h want %h", obs(), exp_st());
    end
    flush();
    total++;
    if (obs() !== exp_st()) begin
      bad++;
      $display("FAIL flush: got %h want %h", obs(), exp_st());
    end
  endtask

  task automatic test_timeout();
    send(8'h3C, 8, 0, 0, 0, 0, 0, 0, -1);
`ifdef UART_RX_TIMEOUT_EN
    ticks(600);
    total++;
    if (rx_tmo !== 1'b0) begin
      bad++;
      $display("FAIL tmo_early: got %b want 0", rx_tmo);
    end
    ticks(60);
    total++;
    if (rx_tmo !== 1'b1) begin
      bad++;
      $display("FAIL tmo_set: got %b want 1", rx_tmo);
    end
    rd();
    total++;
    if ({rx_tmo, obs()} !== {1'b0, exp_st()}) begin
      bad++;
      $display("FAIL tmo_clear: got %h want %h", {rx_tmo, obs()}, {1'b0, exp_st()});
    end
`else
    ticks(700);
    total++;
    if ({rx_tmo, obs()} !== {1'b0, exp_st()}) begin
      bad++;
      $display("FAIL tmo_absent: got %h want %h", {rx_tmo, obs()}, {1'b0, exp_st()});
    end
    rd();
`endif
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    test_reset();
    test_8n1();
    test_7e2_err();
    test_glitch();
    test_random();
    test_break();
    test_overrun();
    test_flush();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
